match_tracker: RTL



---
 rtl/match_tracker.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/match_tracker.sv
// match_tracker: qualifies comparator eqo with a strobe, tracks match runs.
// Optional MATCH_TRACKER_STATS_EN adds total_samples/total_matches counters.
module match_tracker #(
   parameter int LOCK_COUNT = 4,
   parameter int MISS_LIMIT = 2,
   parameter int CNT_W      = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             sample_valid,
   input  logic             eqo,
   input  logic [2:0]       x,
   output logic [1:0]       state,
   output logic             locked,
   output logic             alarm,
   output logic             lock_pulse,
   output logic             alarm_pulse,
   output logic [CNT_W-1:0] streak,
   output logic [2:0]       lock_value
`ifdef MATCH_TRACKER_STATS_EN
   ,
   output logic [CNT_W-1:0] total_samples,
   output logic [CNT_W-1:0] total_matches
`endif
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] TRACK  = 2'd1;
   localparam logic [1:0] LOCKED = 2'd2;
   localparam logic [1:0] ALARM  = 2'd3;

   localparam logic [CNT_W-1:0] CMAX = '1;
   localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] LC   = CNT_W'(LOCK_COUNT);
   localparam logic [CNT_W-1:0] ML   = CNT_W'(MISS_LIMIT);

   logic [CNT_W-1:0] miss;
   logic [CNT_W-1:0] inc_streak;
   logic [CNT_W-1:0] inc_miss;

   logic [1:0]       st_n;
   logic [CNT_W-1:0] sk_n;
   logic [CNT_W-1:0] ms_n;
   logic [2:0]       lv_n;
   logic             lp_n;
   logic             ap_n;

   assign inc_streak = (streak == CMAX) ? streak : streak + ONE;
   assign inc_miss   = (miss == CMAX) ? miss : miss + ONE;

   always_comb begin
      st_n = state;
      sk_n = streak;
      ms_n = miss;
      lv_n = lock_value;
      lp_n = 1'b0;
      ap_n = 1'b0;
      if (sample_valid && state != ALARM) begin
         sk_n = eqo ? inc_streak : '0;
         unique case (1'b1)
            // IDLE always holds streak=0, so it shares TRACK's lock test
            (state == IDLE),
            (state == TRACK): begin
               if (!eqo) begin
                  st_n = IDLE;
               end else if (inc_streak == LC) begin
                  st_n = LOCKED;
                  lp_n = 1'b1;
                  lv_n = x;
               end else begin
                  st_n = TRACK;
               end
            end
            (state == LOCKED): begin
               if (eqo) begin
                  ms_n = '0;
               end else begin
                  ms_n = inc_miss;
                  if (inc_miss == ML) begin
                     st_n = ALARM;
                     ap_n = 1'b1;
                  end
               end
            end
            (state == ALARM): begin
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         locked      <= 1'b0;
         alarm       <= 1'b0;
         lock_pulse  <= 1'b0;
         alarm_pulse <= 1'b0;
         streak      <= '0;
         lock_value  <= '0;
         miss        <= '0;
      end else if (clr) begin
         state       <= IDLE;
         locked      <= 1'b0;
         alarm       <= 1'b0;
         lock_pulse  <= 1'b0;
         alarm_pulse <= 1'b0;
         streak      <= '0;
         lock_value  <= '0;
         miss        <= '0;
      end else begin
         state       <= st_n;
         locked      <= (st_n == LOCKED);
         alarm       <= (st_n == ALARM);
         lock_pulse  <= lp_n;
         alarm_pulse <= ap_n;
         streak      <= sk_n;
         lock_value  <= lv_n;
         miss        <= ms_n;
      end
   end

`ifdef MATCH_TRACKER_STATS_EN
   // Counted in every state, ALARM included
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         total_samples <= '0;
         total_matches <= '0;
      end else if (clr) begin
         total_samples <= '0;
         total_matches <= '0;
      end else if (sample_valid) begin
         if (total_samples != CMAX)
            total_samples <= total_samples + ONE;
         if (eqo && total_matches != CMAX)
            total_matches <= total_matches + ONE;
      end
   end
`endif

endmodule
